// File: rtl/apb_cfg_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_cfg_slave_if                                          |
// | Brief    : APB bus bundle between an APB master and apb_cfg_slave.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface apb_cfg_slave_if #(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 16
);
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_WD-1:0]     PADDR;
    logic [DATA_WD-1:0]     PWDATA;
    logic [DATA_WD/8-1:0]   PSTRB;
    logic                   PREADY;
    logic [DATA_WD-1:0]     PRDATA;
    logic                   PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_cfg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_cfg_slave                                             |
// | Brief    : APB slave posting writes into a FIFO and forwarding them  |
// |            and ordered reads to the config-space backend.            |
// |            Optional read timeout: define APB_CFG_TIMEOUT_EN.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module apb_cfg_slave #(
    parameter int DATA_WD     = 32,
    parameter int ADDR_WD     = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire                          PCLK,
    input  wire                          PRESETn,
    apb_cfg_slave_if.slave               apb,
    output logic                         APB_Request,
    input  wire                          APB_Grant,
    output logic [ADDR_WD-1:0]           APB_OADDR,
    output logic [DATA_WD-1:0]           APB_ODATA,
    output logic [DATA_WD/8-1:0]         APB_OSTRB,
    output logic                         APB_OWRITE,
    input  wire                          ConfigSp_ACKAPB,
    input  wire                          ConfigSp_APBValid,
    input  wire  [DATA_WD-1:0]           ConfigSp_DATA,
    input  wire                          ConfigSp_ERR,
    output logic                         WR_ERR,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_SW = DATA_WD / 8;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DRAIN = 2'd1,
        R_ISSUE = 2'd2,
        R_DONE  = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_REQ  = 2'd1,
        B_ACK  = 2'd2
    } bk_state_t;

    rd_state_t          r_rstate;
    bk_state_t          r_bstate;

    logic [ADDR_WD-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WD-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_SW-1:0]    r_fifo_strb [FIFO_DEPTH];
    logic [c_PW:0]      r_wr_ptr;
    logic [c_PW:0]      r_rd_ptr;

    logic               r_bk_write;
    logic [ADDR_WD-1:0] r_rd_addr;
    logic               r_pready;
    logic               r_pslverr;
    logic [DATA_WD-1:0] r_prdata;
    logic               r_wr_err;

    logic               w_aligned;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_access;
    logic               w_rd_ack;
    logic               w_err_setup;
    logic               w_grant_cyc;
    logic               w_timeout;

    assign w_aligned   = (apb.PADDR[1:0] == 2'b00);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                         (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
    assign w_push      = apb.PSEL & apb.PENABLE & apb.PWRITE & w_aligned & ~w_full;
    assign w_pop       = (r_bstate == B_ACK) & r_bk_write & ConfigSp_ACKAPB;
    assign w_rd_access = apb.PSEL & apb.PENABLE & ~apb.PWRITE & w_aligned;
    assign w_rd_ack    = (r_bstate == B_ACK) & ~r_bk_write & ConfigSp_ACKAPB;
    // Misalignment is caught in the setup phase so the registered PREADY lands in the first access cycle.
    assign w_err_setup = apb.PSEL & ~apb.PENABLE & ~w_aligned;
    assign w_grant_cyc = (r_bstate == B_REQ) & APB_Grant;

`ifdef APB_CFG_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt <= '0;
        end else if ((r_bstate == B_ACK) && !r_bk_write) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_bstate == B_ACK) & ~r_bk_write &
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));
`else
    // Timeout length has no effect when the timeout logic is not built.
    localparam int c_TIMEOUT_UNUSED = TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[c_PW-1:0]] <= apb.PADDR;
            r_fifo_data[r_wr_ptr[c_PW-1:0]] <= apb.PWDATA;
            r_fifo_strb[r_wr_ptr[c_PW-1:0]] <= apb.PSTRB;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Backend FSM: buffered writes always win over the pending read.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_bstate   <= B_IDLE;
            r_bk_write <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_err <= 1'b0;
            case (r_bstate)
                B_IDLE: begin
                    if (!w_empty || w_push) begin
                        r_bk_write <= 1'b1;
                        r_bstate   <= B_REQ;
                    end else if (r_rstate == R_ISSUE) begin
                        r_bk_write <= 1'b0;
                        r_bstate   <= B_REQ;
                    end
                end
                B_REQ: begin
                    if (APB_Grant) r_bstate <= B_ACK;
                end
                B_ACK: begin
                    if (ConfigSp_ACKAPB) begin
                        r_bstate <= B_IDLE;
                        r_wr_err <= r_bk_write & ConfigSp_ERR;
                    end else if (w_timeout) begin
                        r_bstate <= B_IDLE;
                    end
                end
                default: r_bstate <= B_IDLE;
            endcase
        end
    end

    // Read FSM; also owns the registered APB response for reads and misaligned accesses.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rstate  <= R_IDLE;
            r_rd_addr <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_access) begin
                        r_rd_addr <= apb.PADDR;
                        r_rstate  <= R_DRAIN;
                    end else if (w_err_setup) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                    end
                end
                R_DRAIN: begin
                    if (w_empty && (r_bstate == B_IDLE)) r_rstate <= R_ISSUE;
                end
                R_ISSUE: begin
                    if (w_rd_ack) begin
                        r_rstate  <= R_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= ConfigSp_ERR;
                        r_prdata  <= ConfigSp_APBValid ? ConfigSp_DATA : '0;
                    end else if (w_timeout) begin
                        r_rstate  <= R_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                    end
                end
                R_DONE: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign apb.PREADY  = w_push | r_pready;
    assign apb.PRDATA  = r_prdata;
    assign apb.PSLVERR = r_pslverr;

    assign APB_Request = (r_bstate == B_REQ);
    assign APB_OWRITE  = w_grant_cyc & r_bk_write;
    assign APB_OADDR   = !w_grant_cyc ? '0 :
                         (r_bk_write ? r_fifo_addr[r_rd_ptr[c_PW-1:0]] : r_rd_addr);
    assign APB_ODATA   = (w_grant_cyc && r_bk_write) ? r_fifo_data[r_rd_ptr[c_PW-1:0]] : '0;
    assign APB_OSTRB   = (w_grant_cyc && r_bk_write) ? r_fifo_strb[r_rd_ptr[c_PW-1:0]] : '0;
    assign WR_ERR      = r_wr_err;
    assign FIFO_LEVEL  = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire
